// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, slot state type and register address decode for the write arbiter
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_CSR    = 2;
    typedef enum logic {EMPTY, FULL} slot_state_e;
    // x0 is hardwired zero and addresses past NREG select nothing
    function automatic logic [NREG-1:0] onehot_addr(input logic [REG_ADDR_W-1:0] addr);
        logic [NREG-1:0] v;
        v = '0;
        if (addr != '0) v[addr] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback requests, register-file load enables and pending-slot status
interface rf_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int NREG    = 32
);
    import rf_pkg::*;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*XLEN-1:0]       req_data;
    logic                          wb_stall;
    logic [NREG-1:0]               rf_sel;
    logic [XLEN-1:0]               rf_wdata;
    logic                          pend_valid;
    logic [REG_ADDR_W-1:0]         pend_addr;
    modport master (
        output req_valid, req_addr, req_data, wb_stall,
        input  req_ready, rf_sel, rf_wdata, pend_valid, pend_addr
    );
    modport slave (
        input  req_valid, req_addr, req_data, wb_stall,
        output req_ready, rf_sel, rf_wdata, pend_valid, pend_addr
    );
endinterface

// File: rtl/rf_write_arbiter_rr_pick.sv
// rr_pick: one-hot grant among valid requesters; round-robin from ptr_i under RF_ARB_ROUND_ROBIN_EN, else lowest index wins
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
`ifdef RF_ARB_ROUND_ROBIN_EN
    input  logic [PW-1:0]      ptr_i,
`endif
    output logic [NUM_REQ-1:0] grant_o
);
`ifdef RF_ARB_ROUND_ROBIN_EN
    logic [NUM_REQ-1:0] rot, pick;
    // rotate so the pointer sits at bit 0, take the lowest set bit, rotate back
    assign rot     = (valid_i >> ptr_i) | (valid_i << (NUM_REQ - int'(ptr_i)));
    assign pick    = rot & (-rot);
    assign grant_o = (pick << ptr_i) | (pick >> (NUM_REQ - int'(ptr_i)));
`else
    assign grant_o = valid_i & (-valid_i);
`endif
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates writeback sources into a one-entry slot driving the register-file write port
// RF_ARB_ROUND_ROBIN_EN selects round-robin arbitration; fixed priority otherwise
module rf_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int NREG    = 32
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);
    import rf_pkg::*;
    slot_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] slot_addr_q, slot_addr_d, win_addr;
    logic [XLEN-1:0]       slot_data_q, slot_data_d, win_data;
    logic [NUM_REQ-1:0]    pick, ready;
    logic                  slot_valid, drain, can_accept, grant;

`ifdef RF_ARB_ROUND_ROBIN_EN
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [PW-1:0] ptr_q, ptr_d;
    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (.valid_i(bus.req_valid), .ptr_i(ptr_q), .grant_o(pick));
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_REQ; i++)
            if (ready[i]) ptr_d = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
`else
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.valid_i(bus.req_valid), .grant_o(pick));
`endif

    assign slot_valid = (state_q == FULL);
    assign drain      = slot_valid & ~bus.wb_stall;
    assign can_accept = ~slot_valid | drain;
    assign ready      = can_accept ? pick : '0;
    assign grant      = |ready;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (ready[i]) begin
                win_addr = bus.req_addr[REG_ADDR_W*i +: REG_ADDR_W];
                win_data = bus.req_data[XLEN*i +: XLEN];
            end
    end

    // a grant reloads the slot even while it drains, keeping one write per cycle
    always_comb begin
        state_d     = state_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        if (grant) begin
            state_d     = FULL;
            slot_addr_d = win_addr;
            slot_data_d = win_data;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            slot_addr_q <= '0;
            slot_data_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rf_sel     = drain ? onehot_addr(slot_addr_q) : '0;
    assign bus.rf_wdata   = slot_data_q;
    assign bus.pend_valid = slot_valid;
    assign bus.pend_addr  = slot_addr_q;
endmodule
